// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared types for the two-requester memory arbiter.
//   state_t : arbiter FSM states (IDLE, REQ, WAIT)
//   owner_t : owner of the outstanding transaction (OWNER_IFU=0, OWNER_LSU=1)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates instruction-fetch (IFU) and load/store (LSU)
// requests onto one shared memory port, one transaction outstanding at a time.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ifu_req_valid/ready/addr         fetch request handshake and address
//   ifu_rsp_valid/data               one-cycle fetch response
//   lsu_req_valid/ready/addr/wen/wdata/wmask   load/store request
//   lsu_rsp_valid/data               one-cycle load data / store ack
//   mem_req_valid/ready/addr/wen/wdata/wmask   request to shared memory
//   mem_rsp_valid/data               one-cycle response from memory
//
// Configuration macro: ARB_RR_EN
//   undefined : fixed priority, LSU wins when both requesters are valid
//   defined   : round-robin, the requester not granted last wins a tie
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rsp_data,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
  output logic                    lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rsp_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  state_t                  state_r;
  state_t                  state_next_s;
  owner_t                  owner_r;
  logic                    grant_s;
  logic                    grant_lsu_s;
  logic                    rsp_done_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    wen_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [MASK_WIDTH-1:0]   wmask_r;

`ifdef ARB_RR_EN
  owner_t                  last_grant_r;
`endif

  // Winner selection when the FSM is able to grant.
  always_comb begin
    grant_lsu_s = 1'b0;
`ifdef ARB_RR_EN
    if (lsu_req_valid && ifu_req_valid) begin
      grant_lsu_s = (last_grant_r == OWNER_IFU);
    end else begin
      grant_lsu_s = lsu_req_valid;
    end
`else
    grant_lsu_s = lsu_req_valid;
`endif
  end

  // A grant happens only in IDLE; reset suppresses it so no handshake is lost.
  assign grant_s    = (state_r == IDLE) && !rst && (ifu_req_valid || lsu_req_valid);
  assign rsp_done_s = (state_r == WAIT) && !rst && mem_rsp_valid;

  // Next-state decode and requester/memory handshake outputs.
  always_comb begin
    state_next_s  = state_r;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    case (state_r)
      IDLE: begin
        ifu_req_ready = grant_s && !grant_lsu_s;
        lsu_req_ready = grant_s && grant_lsu_s;
        if (grant_s) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT: begin
        ifu_rsp_valid = rsp_done_s && (owner_r == OWNER_IFU);
        lsu_rsp_valid = rsp_done_s && (owner_r == OWNER_LSU);
        if (rsp_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state, transaction owner and (optionally) last-grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= OWNER_IFU;
`ifdef ARB_RR_EN
      last_grant_r <= OWNER_IFU;
`endif
    end else begin
      state_r <= state_next_s;
      if (grant_s) begin
        if (grant_lsu_s) begin
          owner_r <= OWNER_LSU;
`ifdef ARB_RR_EN
          last_grant_r <= OWNER_LSU;
`endif
        end else begin
          owner_r <= OWNER_IFU;
`ifdef ARB_RR_EN
          last_grant_r <= OWNER_IFU;
`endif
        end
      end
    end
  end

  // Latched request fields; held stable through REQ, so no reset needed.
  always_ff @(posedge clk) begin
    if (grant_s) begin
      if (grant_lsu_s) begin
        addr_r  <= lsu_req_addr;
        wen_r   <= lsu_req_wen;
        wdata_r <= lsu_req_wdata;
        wmask_r <= lsu_req_wmask;
      end else begin
        addr_r  <= ifu_req_addr;
        wen_r   <= 1'b0;
        wdata_r <= '0;
        wmask_r <= '0;
      end
    end
  end

  assign mem_req_addr  = addr_r;
  assign mem_req_wen   = wen_r;
  assign mem_req_wdata = wdata_r;
  assign mem_req_wmask = wmask_r;

  // Response data is broadcast; only the valid pulse is steered by owner.
  assign ifu_rsp_data = mem_rsp_data;
  assign lsu_rsp_data = mem_rsp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled in the same half-cycle, away from the active edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
    checks++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got ifu=%b lsu=%b want 0/0", ifu_req_ready, lsu_req_ready); end
    checks++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got ifu=%b lsu=%b want 0/0", ifu_rsp_valid, lsu_rsp_valid); end
  endtask

  task automatic test_ifu_fetch();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1'b1;
    #1;
    checks++; if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL fetch_grant: got ifu=%b lsu=%b want 1/0", ifu_req_ready, lsu_req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle_mem_valid: got %b want 0", mem_req_valid); end
    tick();
    ifu_req_valid = 1'b0; ifu_req_addr = 32'h1234_5678;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wen !== 1'b0) begin errors++; $display("FAIL fetch_mem_req: got v=%b a=%h w=%b want 1/80000000/0", mem_req_valid, mem_req_addr, mem_req_wen); end
    checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_in_req: got %b want 0", ifu_req_ready); end
    tick();
    mem_req_ready = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_wait: got mv=%b rv=%b want 0/0", mem_req_valid, ifu_rsp_valid); end
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
    #1;
    checks++; if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h0000_0413) begin errors++; $display("FAIL fetch_rsp: got v=%b d=%h want 1/00000413", ifu_rsp_valid, ifu_rsp_data); end
    checks++; if (lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_lsu_quiet: got %b want 0", lsu_rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_rsp_single: got %b want 0", ifu_rsp_valid); end
  endtask

  task automatic test_store_stall();
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_1004;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0011; mem_req_ready = 1'b0;
    #1;
    checks++; if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin errors++; $display("FAIL store_grant: got lsu=%b ifu=%b want 1/0", lsu_req_ready, ifu_req_ready); end
    tick();
    lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = 32'h0;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1'b1;
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_1004 || mem_req_wen !== 1'b1 ||
          mem_req_wdata !== 32'hDEAD_BEEF || mem_req_wmask !== 4'b0011) begin
        errors++;
        $display("FAIL store_stable_%0d: got v=%b a=%h w=%b d=%h m=%b want 1/80001004/1/deadbeef/0011",
                 i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
      end
      tick();
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    #1;
    checks++; if (lsu_rsp_valid !== 1'b1 || ifu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL store_ack: got lsu=%b ifu=%b mv=%b want 1/0/0", lsu_rsp_valid, ifu_rsp_valid, mem_req_valid); end
    checks++; if (ifu_rsp_data !== 32'h1234_5678 || lsu_rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL rsp_data_bcast: got ifu=%h lsu=%h want 12345678", ifu_rsp_data, lsu_rsp_data); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL store_ack_single: got %b want 0", lsu_rsp_valid); end
  endtask

  // Runs after an LSU transaction, so round-robin must favour IFU.
  task automatic test_priority();
    logic       first_lsu;
    logic [31:0] first_addr;
    logic [31:0] second_addr;
`ifdef ARB_RR_EN
    first_lsu = 1'b0;
`else
    first_lsu = 1'b1;
`endif
    first_addr  = first_lsu ? 32'h0000_0200 : 32'h0000_0100;
    second_addr = first_lsu ? 32'h0000_0100 : 32'h0000_0200;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_0100;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0200; lsu_req_wen = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (lsu_req_ready !== first_lsu || ifu_req_ready !== !first_lsu) begin errors++; $display("FAIL prio_first_grant: got lsu=%b ifu=%b want %b/%b", lsu_req_ready, ifu_req_ready, first_lsu, !first_lsu); end
    tick();
    if (first_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
    #1;
    checks++; if (mem_req_addr !== first_addr || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL prio_first_req: got a=%h rdy=%b%b want %h/00", mem_req_addr, ifu_req_ready, lsu_req_ready, first_addr); end
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5_0001;
    #1;
    checks++; if (lsu_rsp_valid !== first_lsu || ifu_rsp_valid !== !first_lsu) begin errors++; $display("FAIL prio_first_rsp: got lsu=%b ifu=%b want %b/%b", lsu_rsp_valid, ifu_rsp_valid, first_lsu, !first_lsu); end
    checks++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin errors++; $display("FAIL prio_no_grant_on_rsp: got ifu=%b lsu=%b want 0/0", ifu_req_ready, lsu_req_ready); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (lsu_req_ready !== !first_lsu || ifu_req_ready !== first_lsu) begin errors++; $display("FAIL prio_second_grant: got lsu=%b ifu=%b want %b/%b", lsu_req_ready, ifu_req_ready, !first_lsu, first_lsu); end
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== second_addr) begin errors++; $display("FAIL prio_second_req: got v=%b a=%h want 1/%h", mem_req_valid, mem_req_addr, second_addr); end
    tick();
    mem_rsp_valid = 1'b1;
    #1;
    checks++; if (lsu_rsp_valid !== !first_lsu || ifu_rsp_valid !== first_lsu) begin errors++; $display("FAIL prio_second_rsp: got lsu=%b ifu=%b want %b/%b", lsu_rsp_valid, ifu_rsp_valid, !first_lsu, first_lsu); end
    tick();
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
  endtask

  task automatic test_spurious_rsp();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_0000;
    #1;
    checks++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL spur_idle_rsp: got ifu=%b lsu=%b want 0/0", ifu_rsp_valid, lsu_rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_0040;
    #1;
    checks++; if (ifu_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL spur_still_idle: got rdy=%b mv=%b want 1/0", ifu_req_ready, mem_req_valid); end
    tick();
    ifu_req_valid = 1'b0; mem_rsp_valid = 1'b1;
    #1;
    checks++; if (ifu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b1) begin errors++; $display("FAIL spur_req_rsp: got rv=%b mv=%b want 0/1", ifu_rsp_valid, mem_req_valid); end
    tick();
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0040) begin errors++; $display("FAIL spur_req_held: got v=%b a=%h want 1/00000040", mem_req_valid, mem_req_addr); end
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
    #1;
    checks++; if (ifu_rsp_valid !== 1'b1) begin errors++; $display("FAIL spur_final_rsp: got %b want 1", ifu_rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h0000_0300; mem_req_ready = 1'b1;
    tick();
    lsu_req_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0; rst = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_in_wait: got mv=%b rv=%b want 0/0", mem_req_valid, lsu_rsp_valid); end
    tick();
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_0BAD;
    #1;
    checks++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_no_rsp: got ifu=%b lsu=%b want 0/0", ifu_rsp_valid, lsu_rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_0080; mem_req_ready = 1'b1;
    #1;
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL rstw_idle_grant: got %b want 1", ifu_req_ready); end
    tick();
    ifu_req_valid = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0080) begin errors++; $display("FAIL rstw_new_req: got v=%b a=%h want 1/00000080", mem_req_valid, mem_req_addr); end
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
    #1;
    checks++; if (ifu_rsp_valid !== 1'b1 || lsu_rsp_valid !== 1'b0 || ifu_rsp_data !== 32'h0000_0013) begin errors++; $display("FAIL rstw_new_rsp: got ifu=%b lsu=%b d=%h want 1/0/00000013", ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data); end
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifu_fetch();
    test_store_stall();
    test_priority();
    test_spurious_rsp();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1);
  end

endmodule
